// File: rtl/keypad_loader_if.sv
// Keypad/button inputs and timer-side load/run/clear signals of the microwave
// front end, bundled as one port.
interface keypad_loader_if;
  logic [9:0] key;
  logic       start;
  logic       stop;
  logic       zero;
  logic [3:0] data;
  logic       loadn;
  logic       en;
  logic       tclearn;
  logic [1:0] digit_count;
  logic       entry_full;

  modport master (
    output key, start, stop, zero,
    input  data, loadn, en, tclearn, digit_count, entry_full
  );

  modport slave (
    input  key, start, stop, zero,
    output data, loadn, en, tclearn, digit_count, entry_full
  );
endinterface

// File: rtl/keypad_loader.sv
// Microwave front end: debounces keypad digits into the timer load stream and
// turns start/stop edges and the timer zero flag into run enable and clear.
//
// state           | meaning
// ST_IDLE         | waiting for a single valid key
// ST_DEBOUNCE     | same key must stay stable for DEBOUNCE_CYCLES samples
// ST_LOAD         | one-cycle loadn pulse carrying the captured digit
// ST_WAIT_RELEASE | press consumed; wait for all keys released
module keypad_loader #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int MAX_DIGITS      = 3
) (
  input logic            clock,
  input logic            clearn,
  keypad_loader_if.slave bus
);

  localparam logic [1:0] ST_IDLE         = 2'd0;
  localparam logic [1:0] ST_DEBOUNCE     = 2'd1;
  localparam logic [1:0] ST_LOAD         = 2'd2;
  localparam logic [1:0] ST_WAIT_RELEASE = 2'd3;

  localparam logic [3:0] DB_LAST = 4'(DEBOUNCE_CYCLES - 1);
  localparam logic [1:0] FULL    = 2'(MAX_DIGITS);

  logic [1:0] state;
  logic [1:0] state_nxt;
  logic [3:0] code;
  logic [3:0] db_cnt;
  logic [3:0] data_q;
  logic       loadn_q;
  logic       en_q;
  logic       tclearn_q;
  logic [1:0] count_q;

  logic       start_d;
  logic       stop_d;
  logic       start_pulse;
  logic       stop_pulse;

  logic [3:0] key_ones;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_none;
  logic       key_same;

  logic       do_clear;
  logic       do_pause;
  logic       do_run;
  logic       auto_stop;
  logic       db_done;
  logic       do_load;

  always_comb begin
    key_ones = '0;
    key_code = '0;
    for (int i = 0; i < 10; i++) begin
      if (bus.key[i]) begin
        key_ones = key_ones + 4'd1;
        key_code = 4'(i);
      end
    end
    key_valid = (key_ones == 4'd1);
    key_none  = (bus.key == '0);
    key_same  = key_valid && (key_code == code);
  end

  // Stop outranks start; a clear at the same edge as a load suppresses the load.
  always_comb begin
    do_clear  = stop_pulse && !en_q;
    do_pause  = stop_pulse && en_q;
    do_run    = start_pulse && !stop_pulse && !en_q && !bus.zero;
    auto_stop = en_q && bus.zero;
    db_done   = (state == ST_DEBOUNCE) && key_same && (db_cnt == 4'd0);
    do_load   = db_done && !en_q && (count_q < FULL) && !do_clear;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (key_valid) state_nxt = ST_DEBOUNCE;
      end
      ST_DEBOUNCE: begin
        if (!key_same)            state_nxt = ST_IDLE;
        else if (db_cnt == 4'd0)  state_nxt = do_load ? ST_LOAD : ST_WAIT_RELEASE;
      end
      ST_LOAD: begin
        state_nxt = ST_WAIT_RELEASE;
      end
      ST_WAIT_RELEASE: begin
        if (key_none) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge clearn) begin
    if (!clearn) begin
      state  <= ST_IDLE;
      code   <= '0;
      db_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_IDLE && key_valid) begin
        code   <= key_code;
        db_cnt <= DB_LAST;
      end else if (state == ST_DEBOUNCE && key_same && db_cnt != 4'd0) begin
        db_cnt <= db_cnt - 4'd1;
      end
    end
  end

  // Edge registers reset high so a button held through reset never fires.
  always_ff @(posedge clock or negedge clearn) begin
    if (!clearn) begin
      start_d     <= 1'b1;
      stop_d      <= 1'b1;
      start_pulse <= 1'b0;
      stop_pulse  <= 1'b0;
    end else begin
      start_d     <= bus.start;
      stop_d      <= bus.stop;
      start_pulse <= bus.start && !start_d;
      stop_pulse  <= bus.stop && !stop_d;
    end
  end

  always_ff @(posedge clock or negedge clearn) begin
    if (!clearn) begin
      data_q    <= '0;
      loadn_q   <= 1'b1;
      en_q      <= 1'b0;
      tclearn_q <= 1'b1;
      count_q   <= '0;
    end else begin
      loadn_q   <= !do_load;
      tclearn_q <= !do_clear;
      if (do_load) data_q <= key_code;

      if (do_pause || auto_stop) en_q <= 1'b0;
      else if (do_run)           en_q <= 1'b1;

      if (do_clear || auto_stop) count_q <= '0;
      else if (do_load)          count_q <= count_q + 2'd1;
    end
  end

  assign bus.data        = data_q;
  assign bus.loadn       = loadn_q;
  assign bus.en          = en_q;
  assign bus.tclearn     = tclearn_q;
  assign bus.digit_count = count_q;
  assign bus.entry_full  = (count_q == FULL);

endmodule

// File: tb/tb_keypad_loader.sv
// Randomized and directed bench for keypad_loader against a press-level
// reference model (key run lengths, button edge schedule, digit counting).
module tb_keypad_loader;

  localparam int D   = 4;
  localparam int MAX = 3;

  logic clock;
  logic clearn;

  keypad_loader_if bus ();

  keypad_loader #(.DEBOUNCE_CYCLES(D), .MAX_DIGITS(MAX)) dut (
    .clock  (clock),
    .clearn (clearn),
    .bus    (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;
  int n_loads = 0;
  int n_clears = 0;

  // model state
  int         m_count;
  int         m_data;
  int         m_run;
  bit         m_en;
  logic [9:0] m_prev_key;
  bit         m_prev_start, m_prev_stop;
  bit         m_start_pend, m_stop_pend;
  bit         exp_loadn, exp_tclearn;

  logic st_lvl, sp_lvl, z_lvl;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_count = 0; m_data = 0; m_run = 0; m_en = 0;
    m_prev_key = '0;
    m_prev_start = 1; m_prev_stop = 1;
    m_start_pend = 0; m_stop_pend = 0;
    exp_loadn = 1; exp_tclearn = 1;
  endtask

  // One rising edge of the specified behaviour, from the inputs present at it.
  task automatic model_edge(input logic [9:0] k, input bit s, input bit p, input bit z);
    bit valid, clr, pause, go, auto_off, ld;
    int kc;
    valid = ($countones(k) == 1);
    kc = 0;
    for (int i = 0; i < 10; i++) if (k[i]) kc = i;
    if (valid && k == m_prev_key) m_run++;
    else if (valid)               m_run = 1;
    else                          m_run = 0;
    m_prev_key = k;

    clr      = m_stop_pend && !m_en;
    pause    = m_stop_pend && m_en;
    go       = m_start_pend && !m_stop_pend && !m_en && !z;
    auto_off = m_en && z;
    ld       = (m_run == D + 1) && !m_en && (m_count < MAX) && !clr;

    exp_loadn   = !ld;
    exp_tclearn = !clr;
    if (ld) m_data = kc;
    if (clr || auto_off) m_count = 0;
    else if (ld)         m_count = m_count + 1;
    if (pause || auto_off) m_en = 0;
    else if (go)           m_en = 1;

    m_start_pend = s && !m_prev_start;
    m_stop_pend  = p && !m_prev_stop;
    m_prev_start = s;
    m_prev_stop  = p;
  endtask

  task automatic step(input logic [9:0] k, input logic s, input logic p, input logic z);
    bus.key = k; bus.start = s; bus.stop = p; bus.zero = z;
    @(posedge clock);
    #1;
    model_edge(k, s, p, z);
    if (bus.loadn === 1'b0) n_loads++;
    if (bus.tclearn === 1'b0) n_clears++;
    check("loadn", int'(bus.loadn), int'(exp_loadn));
    check("data", int'(bus.data), m_data);
    check("en", int'(bus.en), int'(m_en));
    check("tclearn", int'(bus.tclearn), int'(exp_tclearn));
    check("digit_count", int'(bus.digit_count), m_count);
    check("entry_full", int'(bus.entry_full), int'(m_count == MAX));
  endtask

  task automatic do_reset();
    clearn = 1'b0;
    #2;
    check("rst_loadn", int'(bus.loadn), 1);
    check("rst_en", int'(bus.en), 0);
    check("rst_data", int'(bus.data), 0);
    check("rst_count", int'(bus.digit_count), 0);
    check("rst_tclearn", int'(bus.tclearn), 1);
    model_reset();
    @(negedge clock);
    clearn = 1'b1;
  endtask

  task automatic press(input int digit, input int hold, input int gap);
    logic [9:0] k;
    k = 10'(1) << digit;
    repeat (hold) step(k, 1'b0, 1'b0, 1'b0);
    repeat (gap) step('0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic rnd_cycle(input logic [9:0] k);
    if ($urandom_range(0, 7) == 0)  st_lvl = ~st_lvl;
    if ($urandom_range(0, 39) == 0) sp_lvl = ~sp_lvl;
    if ($urandom_range(0, 19) == 0) z_lvl = ~z_lvl;
    step(k, st_lvl, sp_lvl, z_lvl);
  endtask

  initial begin
    int base_l, base_c;
    clearn = 1'b1;
    bus.key = '0; bus.start = 1'b0; bus.stop = 1'b0; bus.zero = 1'b0;
    st_lvl = 1'b0; sp_lvl = 1'b0; z_lvl = 1'b0;
    model_reset();
    #1;
    do_reset();

    // single long press of 8
    n_loads = 0;
    repeat (2) step('0, 1'b0, 1'b0, 1'b0);
    press(8, 10, 4);
    check("t1_loads", n_loads, 1);
    check("t1_count", int'(bus.digit_count), 1);
    check("t1_data", int'(bus.data), 8);

    // bounce and multi-key patterns never load
    do_reset();
    base_l = n_loads;
    press(3, 2, 1);
    press(3, 2, 2);
    repeat (6) step(10'b0000100100, 1'b0, 1'b0, 1'b0);
    repeat (2) step('0, 1'b0, 1'b0, 1'b0);
    check("t3_loads", n_loads - base_l, 0);

    // three digits fill the entry, a fourth is ignored
    press(8, 6, 3);
    press(5, 6, 3);
    press(7, 6, 3);
    check("t2_full", int'(bus.entry_full), 1);
    base_l = n_loads;
    press(2, 6, 3);
    check("t2_extra_loads", n_loads - base_l, 0);
    check("t2_data", int'(bus.data), 7);

    // run, press while running, pause, clear
    step('0, 1'b1, 1'b0, 1'b0);
    step('0, 1'b1, 1'b0, 1'b0);
    check("t4_en_run", int'(bus.en), 1);
    step('0, 1'b0, 1'b0, 1'b0);
    base_l = n_loads;
    press(4, 8, 3);
    check("t4_run_loads", n_loads - base_l, 0);
    repeat (2) step('0, 1'b0, 1'b1, 1'b0);
    repeat (2) step('0, 1'b0, 1'b0, 1'b0);
    check("t4_paused_en", int'(bus.en), 0);
    check("t4_paused_count", int'(bus.digit_count), 3);
    base_c = n_clears;
    repeat (2) step('0, 1'b0, 1'b1, 1'b0);
    repeat (2) step('0, 1'b0, 1'b0, 1'b0);
    check("t4_clear_pulses", n_clears - base_c, 1);
    check("t4_clear_count", int'(bus.digit_count), 0);

    // auto-stop on zero, start blocked by zero, simultaneous edges
    press(6, 6, 3);
    repeat (3) step('0, 1'b1, 1'b0, 1'b0);
    check("t5_en_run", int'(bus.en), 1);
    repeat (2) step('0, 1'b0, 1'b0, 1'b1);
    check("t5_auto_en", int'(bus.en), 0);
    check("t5_auto_count", int'(bus.digit_count), 0);
    repeat (3) step('0, 1'b1, 1'b0, 1'b1);
    check("t5_zero_start_en", int'(bus.en), 0);
    repeat (2) step('0, 1'b0, 1'b0, 1'b0);
    base_c = n_clears;
    repeat (3) step('0, 1'b1, 1'b1, 1'b0);
    check("t5_both_en", int'(bus.en), 0);
    check("t5_both_clear", n_clears - base_c, 1);
    repeat (2) step('0, 1'b0, 1'b0, 1'b0);
    repeat (3) step('0, 1'b1, 1'b0, 1'b0);
    repeat (3) step('0, 1'b1, 1'b1, 1'b0);
    check("t5_both_pause", int'(bus.en), 0);
    repeat (2) step('0, 1'b0, 1'b0, 1'b0);

    // reset mid-debounce and mid-load, key held through release
    press(2, 2, 0);
    do_reset();
    base_l = n_loads;
    press(5, 8, 3);
    check("t6_db_loads", n_loads - base_l, 1);
    check("t6_db_data", int'(bus.data), 5);
    press(1, D + 1, 0);
    check("t6_load_seen", int'(bus.loadn), 0);
    do_reset();
    base_l = n_loads;
    press(1, 8, 3);
    check("t6_ld_loads", n_loads - base_l, 1);
    check("t6_ld_count", int'(bus.digit_count), 1);

    // randomized segments, separated by at least two idle samples
    for (int s = 0; s < 300; s++) begin
      int kind, len, a, b;
      logic [9:0] kv;
      kind = $urandom_range(0, 9);
      if (kind < 6) begin
        kv = 10'(1) << $urandom_range(0, 9);
        len = $urandom_range(1, 10);
      end else if (kind < 8) begin
        a = $urandom_range(0, 9);
        b = (a + $urandom_range(1, 9)) % 10;
        kv = (10'(1) << a) | (10'(1) << b);
        len = $urandom_range(1, 6);
      end else begin
        kv = '0;
        len = $urandom_range(1, 4);
      end
      for (int c = 0; c < len; c++) rnd_cycle(kv);
      len = $urandom_range(2, 4);
      for (int c = 0; c < len; c++) rnd_cycle('0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/keypad_loader.md
Name: keypad_loader

Overview:
- Front-end controller for the microwave timer.
- Turns raw keypad, start and stop buttons into the timer's digit-load stream (data/loadn), run enable (en) and clear strobe (tclearn).
- Consumes the timer's zero flag to end a cook cycle.
- Sits between the keypad/button inputs and the timer.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive cycles a single key must be stable before it is accepted (legal range 1..15)
MAX_DIGITS, 3, maximum digits accepted per entry (legal range 1..3)

Ports:
clock  input  1  system clock, rising-edge
clearn  input  1  asynchronous active-low reset
key  input  10  keypad lines; bit n high = digit n pressed
start  input  1  start button, level, active-high
stop  input  1  stop/clear button, level, active-high
zero  input  1  timer zero flag
data  output  4  digit value presented to the timer
loadn  output  1  active-low load strobe to the timer, one cycle per digit
en  output  1  timer count enable
tclearn  output  1  active-low timer clear strobe, one cycle
digit_count  output  2  digits accepted since the last clear or finished cycle
entry_full  output  1  high when digit_count == MAX_DIGITS

Behaviour:
- Reset (clearn low, async) state:
  - FSM = IDLE, data=0, loadn=1, en=0, tclearn=1, digit_count=0.
  - start/stop edge-detect registers = 1, so a button held through reset never fires.
- All outputs are registered.
- Key classification, each cycle:
  - Valid: exactly one key bit high; its code is the index 0..9.
  - None: key == 0.
  - Invalid: more than one bit high.
- Digit FSM states:
  - IDLE: on a valid key, capture code, cnt=1, go to DEBOUNCE. Otherwise stay.
  - DEBOUNCE: if the same valid code is present, cnt++.
    - When cnt reaches DEBOUNCE_CYCLES: go to LOAD if en==0 and digit_count<MAX_DIGITS, otherwise go to WAIT_RELEASE.
    - Any change (other code, none, invalid) returns to IDLE, with no load.
  - LOAD: for exactly one cycle, loadn=0 and data=code. digit_count++. Go to WAIT_RELEASE.
  - WAIT_RELEASE: stay while key != 0. One cycle of key == 0 returns to IDLE.
- Load timing:
  - With DEBOUNCE_CYCLES=D, loadn goes low on the (D+1)th rising edge after the key first appears.
  - Exactly one load per press, regardless of hold time.
- Between loads, data holds the last loaded digit. Timer contract: on each loadn=0 clock edge it shifts data into sec_ones and moves earlier digits up.
- Start/stop edges:
  - Rising edges are detected with a 1-cycle delayed copy. Edges act on the cycle after detection.
  - Stop edge with en=1: en=0 (pause). digit_count unchanged.
  - Stop edge with en=0: tclearn=0 for one cycle, digit_count=0.
  - Start edge with en=0 and zero=0: en=1.
  - Start edge with zero=1: ignored.
  - Start edge with en=1: ignored.
  - Simultaneous start and stop edges: stop wins; start is discarded.
- End of cycle: zero==1 while en==1 sets en=0 and digit_count=0 next cycle (auto-stop).
- Key handling while en==1: presses are debounced but never loaded (DEBOUNCE goes to WAIT_RELEASE).
- Full entry: with digit_count==MAX_DIGITS, further presses are ignored (no loadn pulse) until a clear or auto-stop.
- Concurrency:
  - A LOAD cycle and a tclearn pulse never coincide; a stop-clear in the same cycle as LOAD suppresses the load and its digit_count increment.
  - The clear forces digit_count=0.
- Reset mid-press or mid-load:
  - All state returns immediately to reset values; loadn returns high asynchronously.
  - A key held through reset release is treated as a new press.
- entry_full is combinational on registered digit_count; digit_count saturates at MAX_DIGITS.

Test Plan:
1. Reset, press key[8] for 10 cycles, release -> a single loadn=0 cycle 5 edges after press with data=8; digit_count=1; no further pulses.
2. Press 8, 5, 7 in turn, each held 6 cycles with 3-cycle gaps -> three loadn pulses with data 8, 5, 7; digit_count=3; entry_full=1. Fourth press of 2 -> no pulse, data stays 7.
3. key[3] high 2 cycles, low 1 cycle, high 2 cycles (bounce); key=10'b0000100100 for 6 cycles -> no loadn pulse at any point.
4. After entry, start edge with zero=0 -> en=1 two cycles later. Press 4 while running -> no load. Stop edge -> en=0 with digit_count=3. Second stop edge -> tclearn low one cycle and digit_count=0.
5. en=1, drive zero=1 -> en=0 next cycle, digit_count=0. Start edge while zero=1 -> en stays 0. Start and stop rising together -> en unchanged, stop action taken.
6. Assert clearn low during DEBOUNCE and during a LOAD cycle -> loadn=1, en=0, data=0, digit_count=0 immediately. Key held across release -> one load D+1 edges later.
